// File: rtl/seg7_pkg.sv
// seg7_pkg: segment/anode encodings and FSM state shared by the
// seg7_capture display-bus receiver and its pattern decoder.
package seg7_pkg;

   // active-low cathodes, bit order gfedcba
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] AN_DIG0 = 4'b1110;
   localparam logic [3:0] AN_DIG1 = 4'b1101;
   localparam logic [3:0] AN_DIG2 = 4'b1011;
   localparam logic [3:0] AN_DIG3 = 4'b0111;
   localparam logic [3:0] AN_NONE = 4'b1111;

   typedef enum logic {
      ST_CAPTURE = 1'b0,
      ST_EMIT    = 1'b1
   } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: classifies one active-low segment pattern as
// a decimal digit, the minus sign or blank.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic       is_digit,
   output logic       is_minus,
   output logic       is_blank,
   output logic [3:0] digit
);

   always_comb begin
      is_digit = 1'b1;
      digit    = 4'd0;
      case (seg)
         SEG_0:   digit = 4'd0;
         SEG_1:   digit = 4'd1;
         SEG_2:   digit = 4'd2;
         SEG_3:   digit = 4'd3;
         SEG_4:   digit = 4'd4;
         SEG_5:   digit = 4'd5;
         SEG_6:   digit = 4'd6;
         SEG_7:   digit = 4'd7;
         SEG_8:   digit = 4'd8;
         SEG_9:   digit = 4'd9;
         default: is_digit = 1'b0;
      endcase
   end

   assign is_minus = (seg == SEG_MINUS);
   assign is_blank = (seg == SEG_BLANK);

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: samples a multiplexed 4-digit 7-segment bus and
// rebuilds the shown value once per frame. SEG7_CAPTURE_ERRCNT_EN adds err_count.
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int FRAME_CYCLES  = 800
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] an,
   input  logic [6:0] seg,
   output logic [3:0] value,
   output logic       valid,
   output logic       err
`ifdef SEG7_CAPTURE_ERRCNT_EN
   ,
   output logic [7:0] err_count
`endif
);

   localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam int WW = $clog2(FRAME_CYCLES);
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
   localparam logic [SW-1:0] STAB_PRE = SW'(STABLE_CYCLES - 2);
   localparam logic [WW-1:0] WIN_LAST = WW'(FRAME_CYCLES - 1);

   state_e        state_q, state_d;
   logic [WW-1:0] win_q, win_d;
   logic [SW-1:0] stab_q, stab_d;
   logic [10:0]   last_q, last_d;
   logic [3:0]    mag_q, mag_d;
   logic          mag_seen_q, mag_seen_d;
   logic          neg_seen_q, neg_seen_d;
   logic          ferr_q, ferr_d;
   logic [3:0]    value_q, value_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;

   logic       is_digit, is_minus, is_blank;
   logic [3:0] digit;
   logic       an_one, an_none, ghost, same, accept;

   seg7_pattern_decode u_dec (
      .seg      (seg),
      .is_digit (is_digit),
      .is_minus (is_minus),
      .is_blank (is_blank),
      .digit    (digit)
   );

   assign an_one  = an inside {AN_DIG0, AN_DIG1, AN_DIG2, AN_DIG3};
   assign an_none = (an == AN_NONE);
   assign ghost   = !an_one && !an_none;
   // a new window always starts a fresh run
   assign same    = ({an, seg} == last_q) && (win_q != '0);

   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      stab_d     = stab_q;
      last_d     = last_q;
      mag_d      = mag_q;
      mag_seen_d = mag_seen_q;
      neg_seen_d = neg_seen_q;
      ferr_d     = ferr_q;
      value_d    = value_q;
      valid_d    = 1'b0;
      err_d      = err_q;
      accept     = 1'b0;
      case (state_q)
         ST_CAPTURE: begin
            win_d  = win_q + 1'b1;
            last_d = {an, seg};
            if (win_q == WIN_LAST) state_d = ST_EMIT;
            if (ghost) begin
               stab_d = '0;
               ferr_d = 1'b1;
            end else if (same) begin
               if (stab_q != STAB_MAX) stab_d = stab_q + 1'b1;
               accept = (stab_q == STAB_PRE);
            end else begin
               stab_d = '0;
            end
            if (accept) begin
               if (an == AN_DIG0) begin
                  if (is_digit && digit <= 4'd8) begin
                     if (mag_seen_q && mag_q != digit) ferr_d = 1'b1;
                     mag_d      = digit;
                     mag_seen_d = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else if (an == AN_DIG1) begin
                  if (is_minus) neg_seen_d = 1'b1;
                  else if (!is_blank) ferr_d = 1'b1;
               end else if (!an_none && !is_blank) begin
                  ferr_d = 1'b1;
               end
            end
         end
         ST_EMIT: begin
            state_d    = ST_CAPTURE;
            win_d      = '0;
            stab_d     = '0;
            mag_seen_d = 1'b0;
            neg_seen_d = 1'b0;
            ferr_d     = 1'b0;
            valid_d    = 1'b1;
            err_d      = ferr_q;
            if (!mag_seen_q) begin
               err_d = 1'b1;
            end else if (!neg_seen_q) begin
               if (mag_q == 4'd8) err_d = 1'b1;
               else value_d = mag_q;
            end else begin
               if (mag_q == 4'd0) err_d = 1'b1;
               else value_d = ~mag_q + 4'd1;
            end
         end
         default: state_d = ST_CAPTURE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_CAPTURE;
         win_q      <= '0;
         stab_q     <= '0;
         last_q     <= '0;
         mag_q      <= '0;
         mag_seen_q <= 1'b0;
         neg_seen_q <= 1'b0;
         ferr_q     <= 1'b0;
         value_q    <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         stab_q     <= stab_d;
         last_q     <= last_d;
         mag_q      <= mag_d;
         mag_seen_q <= mag_seen_d;
         neg_seen_q <= neg_seen_d;
         ferr_q     <= ferr_d;
         value_q    <= value_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   assign value = value_q;
   assign valid = valid_q;
   assign err   = err_q;

`ifdef SEG7_CAPTURE_ERRCNT_EN
   logic [7:0] ecnt_q, ecnt_d;

   always_comb begin
      ecnt_d = ecnt_q;
      if (state_q == ST_EMIT && err_d && ecnt_q != 8'hff)
         ecnt_d = ecnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ecnt_q <= '0;
      else        ecnt_q <= ecnt_d;
   end

   assign err_count = ecnt_q;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed and randomized frames against a run-length
// reference model of the display-bus receiver.
module tb_seg7_capture;

   localparam int S = 4;
   localparam int F = 160;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] an = 4'hf;
   logic [6:0] seg = 7'h7f;
   logic [3:0] value;
   logic       valid;
   logic       err;
`ifdef SEG7_CAPTURE_ERRCNT_EN
   logic [7:0] err_count;
   int         exp_ecnt = 0;
`endif

   int n_chk = 0;
   int n_fail = 0;

   logic [3:0] fan  [F];
   logic [6:0] fseg [F];
   logic [3:0] exp_value = 4'd0;
   logic       exp_err = 1'b0;

   logic [6:0] seg_tab [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   always #5 clk = ~clk;

   seg7_capture #(
      .STABLE_CYCLES (S),
      .FRAME_CYCLES  (F)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .an    (an),
      .seg   (seg),
      .value (value),
      .valid (valid),
      .err   (err)
`ifdef SEG7_CAPTURE_ERRCNT_EN
      ,
      .err_count (err_count)
`endif
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fill(input int s, input int n,
                       input logic [3:0] a, input logic [6:0] g);
      for (int i = s; i < s + n; i++) begin
         fan[i]  = a;
         fseg[i] = g;
      end
   endtask

   // reference: a run of S identical legal samples inside the window
   // is one accepted pattern; ghosts flag the frame and break runs
   function automatic void model_frame();
      int   mags[$];
      bit   neg;
      bit   ferr;
      int   run;
      logic [10:0] cur;
      logic [10:0] prev;
      neg  = 0;
      ferr = 0;
      run  = 0;
      prev = '1;
      for (int i = 0; i < F; i++) begin
         cur = {fan[i], fseg[i]};
         if (!(fan[i] inside {4'b1110, 4'b1101, 4'b1011,
                              4'b0111, 4'b1111})) begin
            ferr = 1;
            run  = 0;
         end else begin
            run = (i > 0 && cur == prev) ? run + 1 : 1;
            if (run == S) begin
               if (fan[i] == 4'b1110) begin
                  int d;
                  d = -1;
                  for (int k = 0; k <= 8; k++)
                     if (fseg[i] == seg_tab[k]) d = k;
                  if (d < 0) ferr = 1;
                  else mags.push_back(d);
               end else if (fan[i] == 4'b1101) begin
                  if (fseg[i] == 7'b0111111) neg = 1;
                  else if (fseg[i] != 7'h7f) ferr = 1;
               end else if (fan[i] != 4'b1111 && fseg[i] != 7'h7f) begin
                  ferr = 1;
               end
            end
         end
         prev = cur;
      end
      foreach (mags[k]) if (mags[k] != mags[0]) ferr = 1;
      exp_err = ferr;
      if (mags.size() == 0) begin
         exp_err = 1'b1;
      end else begin
         int m;
         m = mags[mags.size() - 1];
         if (!neg && m <= 7) exp_value = 4'(m);
         else if (neg && m >= 1) exp_value = 4'(16 - m);
         else exp_err = 1'b1;
      end
   endfunction

   task automatic run_frame(input string tag);
      int vc;
      vc = 0;
      for (int c = 0; c < F; c++) begin
         @(negedge clk);
         an  = fan[c];
         seg = fseg[c];
         @(posedge clk);
         #1;
         if (valid) vc++;
      end
      // the emit-cycle sample must be ignored whatever it is
      @(negedge clk);
      an  = 4'($urandom);
      seg = 7'($urandom);
      @(posedge clk);
      #1;
      model_frame();
      chk({tag, "_novalid"}, 8'(vc), 8'd0);
      chk({tag, "_valid"}, 8'(valid), 8'd1);
      chk({tag, "_value"}, 8'(value), 8'(exp_value));
      chk({tag, "_err"}, 8'(err), 8'(exp_err));
`ifdef SEG7_CAPTURE_ERRCNT_EN
      if (exp_err && exp_ecnt < 255) exp_ecnt++;
      chk({tag, "_ecnt"}, err_count, 8'(exp_ecnt));
`endif
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      an    = 4'hf;
      seg   = 7'h7f;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      exp_value = 4'd0;
      exp_err   = 1'b0;
`ifdef SEG7_CAPTURE_ERRCNT_EN
      exp_ecnt = 0;
`endif
   endtask

   task automatic rand_frame();
      int i;
      int mode;
      logic [3:0] m;
      i    = 0;
      mode = $urandom_range(0, 2);
      m    = 4'($urandom_range(0, 8));
      while (i < F) begin
         int len;
         int p;
         logic [3:0] a;
         logic [6:0] g;
         p = $urandom_range(0, 99);
         if (mode < 2) begin
            len = $urandom_range(1, 30);
            if (p < 50) begin
               a = 4'b1110; g = seg_tab[m];
            end else if (p < 80 && mode == 0) begin
               a = 4'b1101; g = 7'b0111111;
            end else if (p < 90) begin
               a = 4'b1111; g = 7'($urandom);
            end else begin
               a = 4'b1101; g = 7'h7f;
            end
         end else begin
            len = $urandom_range(1, 8);
            if (p < 35) begin
               a = 4'b1110; g = seg_tab[$urandom_range(0, 9)];
            end else if (p < 45) begin
               a = 4'b1110; g = 7'($urandom);
            end else if (p < 65) begin
               a = 4'b1101;
               g = (p < 60) ? 7'b0111111 : 7'($urandom);
            end else if (p < 80) begin
               a = (p < 72) ? 4'b1011 : 4'b0111;
               g = (p < 77) ? 7'h7f : 7'($urandom);
            end else if (p < 97) begin
               a = 4'b1111; g = 7'($urandom);
            end else begin
               a = 4'b1100; g = 7'($urandom);
            end
         end
         for (int k = 0; k < len && i < F; k++) begin
            fan[i]  = a;
            fseg[i] = g;
            i++;
         end
      end
   endtask

   initial begin
      do_reset();
      #1;
      chk("rst_value", 8'(value), 8'd0);
      chk("rst_valid", 8'(valid), 8'd0);
      chk("rst_err", 8'(err), 8'd0);
`ifdef SEG7_CAPTURE_ERRCNT_EN
      chk("rst_ecnt", err_count, 8'd0);
`endif

      fill(0, F, 4'b1110, 7'b0110000);
      run_frame("d3");

      fill(0, F / 2, 4'b1110, 7'b1111001);
      fill(F / 2, F / 2, 4'b1101, 7'b0111111);
      run_frame("neg1");

      for (int i = 0; i < F; i += 20) begin
         fill(i, 10, 4'b1110, 7'b0000000);
         fill(i + 10, 10, 4'b1101, 7'b0111111);
      end
      run_frame("neg8");

      fill(0, F, 4'b1110, 7'b0000000);
      run_frame("pos8");

      for (int i = 0; i < F; i++)
         fill(i, 1, 4'b1110, ((i / 2) % 2) ? 7'b0110000 : 7'b0010010);
      run_frame("toggle");

      fill(0, F, 4'b1110, 7'b0100100);
      fill(50, 1, 4'b1100, 7'b0100100);
      run_frame("ghost");

      fill(0, F - S, 4'b1111, 7'h7f);
      fill(F - S, S, 4'b1110, 7'b0010010);
      run_frame("edge_in");

      fill(0, F - S + 1, 4'b1111, 7'h7f);
      fill(F - S + 1, S - 1, 4'b1110, 7'b1111000);
      run_frame("edge_out");

      fill(0, F, 4'b1110, 7'b1111000);
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         an  = fan[c];
         seg = fseg[c];
         @(posedge clk);
         #1;
      end
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_value", 8'(value), 8'd0);
      chk("midrst_valid", 8'(valid), 8'd0);
      chk("midrst_err", 8'(err), 8'd0);
      do_reset();
      fill(0, F, 4'b1110, 7'b0000010);
      run_frame("after_rst");

      for (int r = 0; r < 24; r++) begin
         rand_frame();
         run_frame($sformatf("rand%0d", r));
      end

`ifdef SEG7_CAPTURE_ERRCNT_EN
      do_reset();
      fill(0, F, 4'b1111, 7'h7f);
      for (int r = 0; r < 3; r++) run_frame("ecnt3");
      chk("ecnt_eq3", err_count, 8'd3);
      for (int r = 0; r < 300; r++) run_frame("ecnt_sat");
      chk("ecnt_eq255", err_count, 8'd255);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
